// File: rtl/cdc_push_arbiter_if.sv
// Requester-side handshake and async-FIFO write-side signals of the push arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface cdc_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wpush;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_wfull;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_wpush, fifo_wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_wpush, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/cdc_push_arbiter.sv
// Round-robin packet arbiter feeding the write side of an async FIFO, with burst
// limit and optional one-cycle gap after each push to cover the wfull lag.
module cdc_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int SAFE_GAP   = 1
) (
  input  logic                wclk,
  input  logic                wrst,
  cdc_push_arbiter_if.slave   bus
);
  localparam int          GW = $clog2(NUM_REQ);
  localparam int          CW = $clog2(MAX_BURST + 1);
  localparam int unsigned N  = NUM_REQ;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] grant_id;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_next;
  logic          gap_flag;
  logic          gap_block;
  logic          grant_ready;
  logic          push;
  logic          beat_last;

  // First valid requester after last_grant, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    int unsigned idx;
    logic        found;
    logic [GW-1:0] gi;
    next_grant = '0;
    found      = 1'b0;
    idx        = 0;
    gi         = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= N) idx = idx - N;
      gi = GW'(idx);
      if (!found && bus.req_valid[gi]) begin
        found      = 1'b1;
        next_grant = gi;
      end
    end
  end

  always_comb begin
    bus.fifo_wdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (GW'(i) == grant_id) bus.fifo_wdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign gap_block     = (SAFE_GAP == 1) && gap_flag;
  assign grant_ready   = (state == GRANT) && !bus.fifo_wfull && !gap_block;
  assign bus.req_ready = grant_ready ? (NUM_REQ'(1) << grant_id) : '0;
  assign push          = grant_ready && bus.req_valid[grant_id];
  assign beat_next     = beat_cnt + 1'b1;
  assign beat_last     = bus.req_last[grant_id] || (beat_next == CW'(MAX_BURST));

  assign bus.fifo_wpush = push;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = (state == GRANT);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      gap_flag   <= 1'b0;
    end else begin
      gap_flag <= push;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id <= next_grant;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (push) begin
            beat_cnt <= beat_next;
            if (beat_last) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cdc_push_arbiter.md
CDC_PUSH_ARBITER -- requirements
Module: cdc_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, range 1..16.
REQ-004 SHALL have parameter SAFE_GAP, default 1: when 1, back-to-back pushes are suppressed.
REQ-005 SHALL have port wclk  in  1: write-domain clock; all logic is on its rising edge.
REQ-006 SHALL have port wrst  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ: per-requester beat valid.
REQ-008 SHALL have port req_data  in  NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_last  in  NUM_REQ: marks the final beat of a packet.
REQ-010 SHALL have port req_ready  out  NUM_REQ: beat accepted when valid and ready are both 1.
REQ-011 SHALL have port fifo_wpush  out  1: push strobe to the async FIFO write side.
REQ-012 SHALL have port fifo_wdata  out  DATA_WIDTH: push payload.
REQ-013 SHALL have port fifo_wfull  in  1: FIFO full flag (wclk domain).
REQ-014 SHALL have port grant_id  out  $clog2(NUM_REQ): currently granted requester index.
REQ-015 SHALL have port busy  out  1: 1 while in state GRANT.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and GRANT.
REQ-017 In IDLE with any req_valid bit high, SHALL select the first requester with valid high, searching round-robin from last_grant+1 modulo NUM_REQ; SHALL register it into grant_id; SHALL move to GRANT on the next edge (1-cycle arbitration latency).
REQ-018 In IDLE, SHALL drive req_ready all 0 and fifo_wpush 0.
REQ-019 In GRANT, req_ready[grant_id] SHALL be combinationally (!fifo_wfull && !gap_block); all other req_ready bits SHALL be 0.
REQ-020 fifo_wpush SHALL equal req_valid[grant_id] && req_ready[grant_id].
REQ-021 fifo_wdata SHALL always equal the req_data slice of grant_id.
REQ-022 SHALL define gap_block as 1 only when SAFE_GAP=1 and fifo_wpush was 1 in the previous cycle, which covers the registered-wfull lag of the FIFO.
REQ-023 SHALL keep a beat counter of width $clog2(MAX_BURST+1): cleared on entering GRANT, incremented on each push.
REQ-024 SHALL leave GRANT for IDLE on a push with req_last=1, or on the push that makes the beat count equal MAX_BURST; last_grant SHALL update to grant_id at that edge.
REQ-025 When req_valid[grant_id] drops in GRANT without req_last, the grant SHALL be held with no push; the beat count SHALL be unchanged.
REQ-026 When fifo_wfull=1 in GRANT, there SHALL be no push, the count SHALL be unchanged and the grant held; pushing SHALL resume in the first cycle fifo_wfull=0 (subject to gap_block).
REQ-027 Requester valid changes outside GRANT SHALL NOT affect an ongoing grant.
REQ-028 MAX_BURST=1 SHALL release after every beat; IDLE SHALL always insert one cycle between grants.
REQ-029 The round-robin pointer SHALL wrap NUM_REQ-1 -> 0.

Reset
REQ-030 On wrst=1, SHALL asynchronously set state to IDLE, beat count 0, last_grant NUM_REQ-1 (requester 0 highest priority first), grant_id 0, and the gap flag 0.
REQ-031 During reset, SHALL hold req_ready 0, fifo_wpush 0 and busy 0.
REQ-032 Reset asserted mid-GRANT SHALL abandon the packet with no further push; after release, arbitration SHALL restart from requester 0.

Verification
REQ-033 After reset, req_valid=4'b1111 with all req_last=1, SAFE_GAP=0, wfull=0 -> grants in order 0,1,2,3,0, with one push per grant and each push 2 cycles after the previous.
REQ-034 Requester 2 sends a 6-beat packet, MAX_BURST=4, with req_valid[1] also high -> 4 pushes from 2, then 1 is granted, then 2 resumes with 2 beats.
REQ-035 SAFE_GAP=1, requester 0 sends a 4-beat packet, wfull=0 -> fifo_wpush pattern 1,0,1,0,1,0,1.
REQ-036 wfull=1 for 3 cycles mid-packet -> req_ready 0 and no push for those 3 cycles, beat count frozen, the next beat pushed on the cycle wfull falls.
REQ-037 wrst pulsed during beat 2 of requester 3, then req_valid=4'b1001 -> no push during reset, and the first grant after reset goes to requester 0.
REQ-038 Requester 1 drops valid for 2 cycles mid-packet while requester 0 is valid -> grant_id stays 1, no push, and the packet completes before requester 0 is granted.
